// File: rtl/toysram_rf_2r1w_if.sv
// Request/response bundle for the toysram 2R1W register file.
// master = array-control side (drives requests), slave = register file.
interface toysram_rf_2r1w_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
);
  logic             clr;
  logic             ready;
  logic             rd0_en;
  logic             rd1_en;
  logic [AW-1:0]    rd0_addr;
  logic [AW-1:0]    rd1_addr;
  logic [WIDTH-1:0] rd0_data;
  logic [WIDTH-1:0] rd1_data;
  logic             rd0_vld;
  logic             rd1_vld;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       err;
  logic             err_clr;

  modport master (
    output clr, rd0_en, rd1_en, rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, err_clr,
    input  ready, rd0_data, rd1_data, rd0_vld, rd1_vld, err
  );

  modport slave (
    input  clr, rd0_en, rd1_en, rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, err_clr,
    output ready, rd0_data, rd1_data, rd0_vld, rd1_vld, err
  );
endinterface

// File: rtl/toysram_rf_2r1w.sv
// DEPTH x WIDTH two-read/one-write register file with hardware clear sweep,
// registered read ports and sticky errors. Define TOYSRAM_RF_BYPASS_EN for write-through reads.
module toysram_rf_2r1w #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  toysram_rf_2r1w_if.slave bus
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_LAST = AW'(DEPTH-1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd0_data;
  logic [WIDTH-1:0] r_rd1_data;
  logic             r_rd0_vld;
  logic             r_rd1_vld;
  logic [1:0]       r_err;
  logic [1:0]       w_err_set;
  logic [WIDTH-1:0] w_rd0_word;
  logic [WIDTH-1:0] w_rd1_word;
  logic             w_run;
  logic             w_init_wr;
  logic             w_rd0_ok;
  logic             w_rd1_ok;
  logic             w_wr_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // State register: clear pointer and INIT/RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: sweep one word per cycle, clr restarts the sweep from word 0
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_INIT: begin
        if (bus.clr) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == PTR_LAST) begin
          w_state_nxt = S_RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.clr) begin
          w_state_nxt = S_INIT;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Output decode: ready comes straight from the state flop
  always_comb begin
    w_run     = (r_state == S_RUN);
    w_init_wr = (r_state == S_INIT);
  end

  assign w_rd0_ok = addr_ok(bus.rd0_addr);
  assign w_rd1_ok = addr_ok(bus.rd1_addr);
  assign w_wr_ok  = addr_ok(bus.wr_addr);

  // Read word select; out-of-range addresses read as zero
  always_comb begin
    w_rd0_word = '0;
    w_rd1_word = '0;
    if (w_rd0_ok) w_rd0_word = r_mem[bus.rd0_addr];
    if (w_rd1_ok) w_rd1_word = r_mem[bus.rd1_addr];
`ifdef TOYSRAM_RF_BYPASS_EN
    if (w_rd0_ok && bus.wr_en && (bus.wr_addr == bus.rd0_addr)) w_rd0_word = bus.wr_data;
    if (w_rd1_ok && bus.wr_en && (bus.wr_addr == bus.rd1_addr)) w_rd1_word = bus.wr_data;
`endif
  end

  always_comb begin
    w_err_set    = 2'b00;
    w_err_set[0] = w_run && ((bus.rd0_en && !w_rd0_ok) ||
                             (bus.rd1_en && !w_rd1_ok) ||
                             (bus.wr_en  && !w_wr_ok));
    w_err_set[1] = w_init_wr && (bus.rd0_en || bus.rd1_en || bus.wr_en);
  end

  // Read-port and error registers; read data holds when no request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd0_data <= '0;
      r_rd1_data <= '0;
      r_rd0_vld  <= 1'b0;
      r_rd1_vld  <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      r_rd0_vld <= w_run && bus.rd0_en;
      r_rd1_vld <= w_run && bus.rd1_en;
      if (w_run && bus.rd0_en) r_rd0_data <= w_rd0_word;
      if (w_run && bus.rd1_en) r_rd1_data <= w_rd1_word;
      r_err <= (r_err & ~{2{bus.err_clr}}) | w_err_set;
    end
  end

  // Array: the clear sweep owns the write port during INIT
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_run && bus.wr_en && w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.ready    = w_run;
  assign bus.rd0_data = r_rd0_data;
  assign bus.rd1_data = r_rd1_data;
  assign bus.rd0_vld  = r_rd0_vld;
  assign bus.rd1_vld  = r_rd1_vld;
  assign bus.err      = r_err;
endmodule
